rv32i_mem_arbiter: RTL and testbench

Shares one single-port, fixed-latency external memory between two requesters: the rv32i core instruction fetch port and the host/bridge port used for program load and debug access. The block sits between `rv32i_top` and the memory controller. It serialises transactions through a small FSM and drives the core's `stall` input until each fetch returns. One transaction is outstanding at a time.

---
 rtl/rv32i_mem_arbiter_pkg.sv | 31 +++
 rtl/rv32i_mem_arbiter_if.sv | 56 +++++
 rtl/rv32i_mem_arbiter_grant.sv | 43 ++++
 rtl/rv32i_mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_mem_arbiter_pkg : shared types for the core/host memory arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWNER_CORE = 1'b0,
    OWNER_HOST = 1'b1
  } arb_owner_e;

  localparam int CNT_W      = 3;
  localparam int RD_LAT_MAX = 4;

  // Latency load value; the counter never needs to hold more than RD_LAT_MAX.
  function automatic logic [CNT_W-1:0] lat_load(input int lat);
    return CNT_W'(lat);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// rv32i_mem_arbiter_if : core fetch, host and memory buses of the arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface rv32i_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic                core_req;
  logic [ADDR_W-1:0]   core_addr;
  logic [DATA_W-1:0]   core_rdata;
  logic                core_rvalid;
  logic                core_stall;

  logic                host_req;
  logic                host_we;
  logic [ADDR_W-1:0]   host_addr;
  logic [DATA_W-1:0]   host_wdata;
  logic [DATA_W/8-1:0] host_wstrb;
  logic [DATA_W-1:0]   host_rdata;
  logic                host_done;

  logic                mem_req;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;

  // Arbiter side.
  modport slave (
    input  core_req, core_addr,
    output core_rdata, core_rvalid, core_stall,
    input  host_req, host_we, host_addr, host_wdata, host_wstrb,
    output host_rdata, host_done,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  // Requesters plus memory controller side.
  modport master (
    output core_req, core_addr,
    input  core_rdata, core_rvalid, core_stall,
    output host_req, host_we, host_addr, host_wdata, host_wstrb,
    input  host_rdata, host_done,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

`default_nettype wire

// File: rtl/rv32i_mem_arbiter_grant.sv
// ---------------------------------------------------------------------------
// mem_arb_grant : combinational owner selection (round-robin if MEM_ARB_RR_EN)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arb_grant
  import rv32i_mem_arbiter_pkg::*;
(
  input  logic       core_req_i,
  input  logic       host_req_i,
  input  arb_owner_e last_owner_i,
  output logic       grant_valid_o,
  output arb_owner_e grant_owner_o
);

  assign grant_valid_o = core_req_i | host_req_i;

`ifdef MEM_ARB_RR_EN
  // On a tie the requester that did not own the last transaction wins.
  always_comb begin
    grant_owner_o = OWNER_CORE;
    if (core_req_i && host_req_i) begin
      grant_owner_o = (last_owner_i == OWNER_CORE) ? OWNER_HOST : OWNER_CORE;
    end else if (host_req_i) begin
      grant_owner_o = OWNER_HOST;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner_i;

  always_comb begin
    grant_owner_o = OWNER_CORE;
    if (!core_req_i && host_req_i) begin
      grant_owner_o = OWNER_HOST;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rv32i_mem_arbiter : serialises core fetches and host accesses onto one
// fixed-latency memory port; MEM_ARB_RR_EN selects round-robin arbitration.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rv32i_mem_arbiter
  import rv32i_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  rv32i_mem_arbiter_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_ISSUE = ISSUE;
  localparam logic [1:0] S_WAIT  = WAIT;
  localparam logic [1:0] S_RESP  = RESP;

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  arb_owner_e          owner_q, owner_d;
  arb_owner_e          last_owner;

  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W/8-1:0] mem_wstrb_q, mem_wstrb_d;

  logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
  logic                core_rvalid_q, core_rvalid_d;
  logic [DATA_W-1:0]   host_rdata_q, host_rdata_d;
  logic                host_done_q, host_done_d;

  logic                grant_valid;
  arb_owner_e          grant_owner;

  mem_arb_grant u_grant (
    .core_req_i    (bus.core_req),
    .host_req_i    (bus.host_req),
    .last_owner_i  (last_owner),
    .grant_valid_o (grant_valid),
    .grant_owner_o (grant_owner)
  );

`ifdef MEM_ARB_RR_EN
  arb_owner_e last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (state_q == S_IDLE && grant_valid) begin
      last_owner_d = grant_owner;
    end
  end

  // Resetting to host lets the core win the first tie.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_owner_q <= OWNER_HOST;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWNER_HOST;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    owner_d       = owner_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wstrb_d   = mem_wstrb_q;
    core_rdata_d  = core_rdata_q;
    core_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          owner_d   = grant_owner;
          mem_req_d = 1'b1;
          state_d   = S_ISSUE;
          if (grant_owner == OWNER_CORE) begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.core_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
          end else begin
            mem_we_d    = bus.host_we;
            mem_addr_d  = bus.host_addr;
            mem_wdata_d = bus.host_wdata;
            mem_wstrb_d = bus.host_wstrb;
          end
        end
      end

      S_ISSUE: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            state_d       = S_RESP;
            core_rvalid_d = (owner_q == OWNER_CORE);
            host_done_d   = (owner_q == OWNER_HOST);
          end else begin
            cnt_d   = lat_load(RD_LAT);
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        // The edge where the counter reaches zero is RD_LAT edges after accept.
        if (cnt_q <= 1) begin
          state_d = S_RESP;
          if (owner_q == OWNER_CORE) begin
            core_rdata_d  = bus.mem_rdata;
            core_rvalid_d = 1'b1;
          end else begin
            host_rdata_d = bus.mem_rdata;
            host_done_d  = 1'b1;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      owner_q       <= OWNER_CORE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wstrb_q   <= '0;
      core_rdata_q  <= '0;
      core_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      host_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      owner_q       <= owner_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wstrb_q   <= mem_wstrb_d;
      core_rdata_q  <= core_rdata_d;
      core_rvalid_q <= core_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      host_done_q   <= host_done_d;
    end
  end

  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wstrb   = mem_wstrb_q;
  assign bus.core_rdata  = core_rdata_q;
  assign bus.core_rvalid = core_rvalid_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_done   = host_done_q;
  assign bus.core_stall  = bus.core_req & ~core_rvalid_q;

endmodule

`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rv32i_mem_arbiter : directed table, corner sequences and random traffic
// against a word-level memory reference. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_rv32i_mem_arbiter;

  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rv32i_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv32i_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Memory contents as seen by the DUT (mem_arr) and as the host intends (ref_arr).
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_arr [logic [31:0]];

  function automatic logic [31:0] key(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem_arr.exists(key(a))) return mem_arr[key(a)];
    return key(a) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    if (ref_arr.exists(key(a))) return ref_arr[key(a)];
    return key(a) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Fixed-latency memory: data for an accept at edge A is only valid at edge A+RD_LAT.
  typedef struct { longint due; logic [31:0] data; } rd_t;
  rd_t    pend[$];
  longint edge_cnt   = 0;
  int     stall_left = 0;
  bit     rand_ready = 1'b0;
  bit     hold_valid = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic [3:0]  hold_wstrb;
  logic        hold_we;

  always @(posedge clk) edge_cnt++;

  always @(negedge clk) begin
    while (pend.size() > 0 && pend[0].due <= edge_cnt) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].due == edge_cnt + 1) bus.mem_rdata = pend[0].data;
    else bus.mem_rdata = $urandom();

    if (bus.mem_req && stall_left > 0) begin
      bus.mem_ready = 1'b0;
      stall_left--;
    end else begin
      bus.mem_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
    end

    if (bus.mem_req) begin
      if (hold_valid) begin
        chk("mem_addr_stable", bus.mem_addr, hold_addr);
        chk("mem_wdata_stable", bus.mem_wdata, hold_wdata);
        chk("mem_wstrb_stable", 32'(bus.mem_wstrb), 32'(hold_wstrb));
        chk1("mem_we_stable", bus.mem_we, hold_we);
      end
      if (bus.mem_ready) begin
        hold_valid = 1'b0;
        if (bus.mem_we)
          mem_arr[key(bus.mem_addr)] = merge(rd_mem(bus.mem_addr), bus.mem_wdata, bus.mem_wstrb);
        else
          pend.push_back('{edge_cnt + 1 + RD_LAT, rd_mem(bus.mem_addr)});
      end else begin
        hold_valid = 1'b1;
        hold_addr  = bus.mem_addr;
        hold_wdata = bus.mem_wdata;
        hold_wstrb = bus.mem_wstrb;
        hold_we    = bus.mem_we;
      end
    end else begin
      if (hold_valid) chk1("mem_req_held", bus.mem_req, 1'b1);
      hold_valid = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk1({tag, "_mem_req"}, bus.mem_req, 1'b0);
    chk1({tag, "_mem_we"}, bus.mem_we, 1'b0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_mem_wstrb"}, 32'(bus.mem_wstrb), 32'h0);
    chk({tag, "_core_rdata"}, bus.core_rdata, 32'h0);
    chk1({tag, "_core_rvalid"}, bus.core_rvalid, 1'b0);
    chk({tag, "_host_rdata"}, bus.host_rdata, 32'h0);
    chk1({tag, "_host_done"}, bus.host_done, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    bit          host;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          stall;
    bit          pre;
    logic [31:0] pre_val;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[7];

  task automatic run_vec(input vec_t v);
    int n, stall_cnt, mreq, fld_bad;
    bit got;
    logic [31:0] rdata;
    @(negedge clk);
    if (v.pre) mem_arr[key(v.addr)] = v.pre_val;
    stall_left = v.stall;
    if (v.host) begin
      bus.host_req = 1'b1; bus.host_we = v.we; bus.host_addr = v.addr;
      bus.host_wdata = v.wdata; bus.host_wstrb = v.wstrb;
    end else begin
      bus.core_req = 1'b1; bus.core_addr = v.addr;
    end
    #1;
    stall_cnt = bus.core_stall ? 1 : 0;
    n = 0; mreq = 0; fld_bad = 0; got = 1'b0; rdata = '0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_req) begin
        mreq++;
        if (bus.mem_addr !== v.addr || bus.mem_we !== v.we) fld_bad++;
        if (v.we && (bus.mem_wdata !== v.wdata || bus.mem_wstrb !== v.wstrb)) fld_bad++;
        if (!v.host && bus.mem_wstrb !== 4'b0000) fld_bad++;
      end
      if (bus.core_stall) stall_cnt++;
      if (v.host ? bus.host_done : bus.core_rvalid) begin
        got   = 1'b1;
        rdata = v.host ? bus.host_rdata : bus.core_rdata;
        bus.host_req = 1'b0;
        bus.core_req = 1'b0;
      end
    end
    chk1("vec_response", got, 1'b1);
    chk("vec_latency", n, v.exp_lat);
    if (!v.we) chk("vec_rdata", rdata, v.exp_rdata);
    chk("vec_stall_cycles", stall_cnt, v.host ? 0 : v.exp_lat);
    chk("vec_mem_req_cycles", mreq, v.stall + 1);
    chk("vec_mem_fields", fld_bad, 0);
    @(negedge clk);
    chk1("vec_single_pulse", v.host ? bus.host_done : bus.core_rvalid, 1'b0);
    chk1("vec_idle_mem_req", bus.mem_req, 1'b0);
  endtask

  task automatic core_driver(input int n);
    int k;
    bit got;
    logic [31:0] a;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(4, 1)) begin
        @(negedge clk);
        if (bus.core_rvalid) chk1("rand_core_spurious", bus.core_rvalid, 1'b0);
      end
      a = 32'h1000 + 32'(4 * $urandom_range(7));
      bus.core_addr = a;
      bus.core_req  = 1'b1;
      got = 1'b0; k = 0;
      while (!got && k < 500) begin
        @(negedge clk);
        k++;
        if (bus.core_rvalid) begin
          got = 1'b1;
          chk("rand_core_rdata", bus.core_rdata, rd_ref(a));
          chk1("rand_core_stall_resp", bus.core_stall, 1'b0);
          bus.core_req = 1'b0;
        end else begin
          chk1("rand_core_stall", bus.core_stall, 1'b1);
        end
      end
      chk1("rand_core_resp", got, 1'b1);
    end
  endtask

  task automatic host_driver(input int n);
    int k;
    bit got, we;
    logic [31:0] a, wd;
    logic [3:0]  ws;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(3)) begin
        @(negedge clk);
        if (bus.host_done) chk1("rand_host_spurious", bus.host_done, 1'b0);
      end
      we = 1'($urandom_range(1));
      a  = 32'h1000 + 32'(4 * $urandom_range(7));
      wd = $urandom();
      ws = 4'($urandom_range(15));
      bus.host_we = we; bus.host_addr = a; bus.host_wdata = wd; bus.host_wstrb = ws;
      bus.host_req = 1'b1;
      got = 1'b0; k = 0;
      while (!got && k < 500) begin
        @(negedge clk);
        k++;
        if (bus.host_done) begin
          got = 1'b1;
          if (we) ref_arr[key(a)] = merge(rd_ref(a), wd, ws);
          else    chk("rand_host_rdata", bus.host_rdata, rd_ref(a));
          bus.host_req = 1'b0;
        end
      end
      chk1("rand_host_resp", got, 1'b1);
    end
  endtask

  initial begin
    int cnt, t, got, mreq_after;
    int resp_t[2];
    logic [31:0] rd[2];
    logic [31:0] a2, rdh;
    int owners[$];

    bus.core_req = 1'b0; bus.core_addr = '0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0;
    bus.host_wdata = '0; bus.host_wstrb = '0;
    bus.mem_ready = 1'b1; bus.mem_rdata = '0;

    vt[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0, 4'h0, 0, 1'b1, 32'h0000_0013, 4, 32'h0000_0013};
    vt[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 3, 1'b1, 32'h1122_3344, 5, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 0, 1'b0, 32'h0, 4, 32'h1122_BEEF};
    vt[3] = '{1'b0, 1'b0, 32'h0000_0004, 32'h0, 4'h0, 2, 1'b1, 32'hCAFE_F00D, 6, 32'hCAFE_F00D};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1, 1'b1, 32'h0BAD_F00D, 5, 32'h0BAD_F00D};
    vt[5] = '{1'b1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF, 0, 1'b0, 32'h0, 2, 32'h0};
    vt[6] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 0, 1'b0, 32'h0, 4, 32'h1234_5678};

    // Reset state
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk1("reset_stall_idle", bus.core_stall, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vt[i]);

    // Contention: both requesters held continuously
    do_reset();
    @(negedge clk);
    bus.core_addr = 32'h1004; bus.core_req = 1'b1;
    bus.host_we = 1'b0; bus.host_addr = 32'h1000; bus.host_req = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.core_rvalid) owners.push_back(0);
      if (bus.host_done) begin owners.push_back(1); cnt++; end
    end
    bus.core_req = 1'b0; bus.host_req = 1'b0;
    repeat (10) @(negedge clk);
    chk1("contend_count", owners.size() >= 7, 1'b1);
`ifdef MEM_ARB_RR_EN
    foreach (owners[i]) chk($sformatf("contend_rr_owner%0d", i), owners[i], i % 2);
`else
    foreach (owners[i]) chk($sformatf("contend_fixed_owner%0d", i), owners[i], 0);
    chk("contend_fixed_host_done", cnt, 0);
`endif

    // Reset during WAIT discards the read
    @(negedge clk);
    mem_arr[32'h40] = 32'hFFFF_FFFF;
    bus.core_addr = 32'h40; bus.core_req = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    chk1("rst_mid_stall", bus.core_stall, 1'b1);
    bus.core_req = 1'b0;
    reset_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.core_rvalid) cnt++;
    end
    chk("rst_late_rvalid", cnt, 0);
    chk("rst_late_rdata", bus.core_rdata, 32'h0);

    // Back-to-back core reads, address updated in RESP
    @(negedge clk);
    mem_arr[32'h0] = 32'h1111_0000; mem_arr[32'h4] = 32'h2222_0004;
    bus.core_addr = 32'h0; bus.core_req = 1'b1;
    t = 0; got = 0; a2 = 32'hFFFF_FFFF;
    while (got < 2 && t < 40) begin
      @(negedge clk);
      t++;
      if (bus.mem_req && got == 1) a2 = bus.mem_addr;
      if (bus.core_rvalid) begin
        resp_t[got] = t;
        rd[got] = bus.core_rdata;
        got++;
        if (got == 1) bus.core_addr = 32'h4;
        else bus.core_req = 1'b0;
      end
    end
    chk("b2b_responses", got, 2);
    chk("b2b_gap", resp_t[1] - resp_t[0], RD_LAT + 3);
    chk("b2b_second_addr", a2, 32'h4);
    chk("b2b_rdata0", rd[0], 32'h1111_0000);
    chk("b2b_rdata1", rd[1], 32'h2222_0004);

    // Host read dropped during WAIT still completes once
    @(negedge clk);
    mem_arr[32'h300] = 32'h3333_3333;
    bus.host_we = 1'b0; bus.host_addr = 32'h300; bus.host_req = 1'b1;
    repeat (2) @(negedge clk);
    bus.host_req = 1'b0;
    cnt = 0; mreq_after = 0; rdh = '0;
    repeat (10) begin
      @(negedge clk);
      if (bus.host_done) begin cnt++; rdh = bus.host_rdata; end
      else if (cnt > 0 && bus.mem_req) mreq_after++;
    end
    chk("drop_done_pulses", cnt, 1);
    chk("drop_rdata", rdh, 32'h3333_3333);
    chk("drop_idle_after", mreq_after, 0);

    // Random traffic with random backpressure
    for (int i = 0; i < 8; i++) begin
      mem_arr[32'h1000 + 32'(4 * i)] = (32'h1000 + 32'(4 * i)) ^ 32'h5A5A_0000;
    end
    rand_ready = 1'b1;
    fork
      core_driver(60);
      host_driver(60);
    join
    rand_ready = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
